// File: rtl/cfifo_rr_scheduler.sv
// cfifo_rr_scheduler
// Round-robin front end sharing one click-based micropipeline stage among N
// clocked requesters. Tokens are launched with 2-phase drive toggles, each
// launch is tagged with its requester index, and the stage's driveNext events
// are mapped back to that requester as done pulses while freeNext is returned.
// DEPTH must be a power of two and at least 2.

module cfifo_rr_scheduler #(
  parameter int N           = 4,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N-1:0]                 i_req,
  output logic [N-1:0]                 o_gnt,
  output logic [N-1:0]                 o_done,
  output logic                         o_drive,
  input  logic                         i_free,
  input  logic                         i_driveNext,
  output logic                         o_freeNext,
  output logic [$clog2(DEPTH+1)-1:0]   o_inflight,
  output logic                         o_err
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [IW:0]   N_C      = (IW + 1)'(N);
  localparam logic [IW:0]   N_ONE    = (IW + 1)'(1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [PW:0]   PTR_ONE  = (PW + 1)'(1);
  localparam logic [PW:0]   FULL_PAT = {1'b1, {PW{1'b0}}};

  typedef enum logic [0:0] {
    ST_IDLE      = 1'b0,
    ST_WAIT_FREE = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [N-1:0]    done_q, done_d;
  logic            drive_q, drive_d;
  logic            fnext_q, fnext_d;
  logic            err_q, err_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [PW:0]     wr_ptr_q, wr_ptr_d;
  logic [PW:0]     rd_ptr_q, rd_ptr_d;
  logic [IW-1:0]   tag_mem_q [DEPTH];

  logic [SYNC_STAGES-1:0] free_sync_q;
  logic [SYNC_STAGES-1:0] dn_sync_q;
  logic                   free_dly_q;
  logic                   dn_dly_q;

  logic            free_ev_s;
  logic            dn_ev_s;
  logic            fifo_empty_s;
  logic            fifo_full_s;
  logic            can_issue_s;
  logic            push_s;
  logic            pop_s;
  logic [IW-1:0]   head_tag_s;
  logic            sel_found_s;
  logic [IW-1:0]   sel_idx_s;
  logic [IW:0]     cand_s;

  // Synchronise the two asynchronous toggles and keep a 1-cycle history for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      free_sync_q <= '0;
      dn_sync_q   <= '0;
      free_dly_q  <= 1'b0;
      dn_dly_q    <= 1'b0;
    end else begin
      free_sync_q <= {free_sync_q[SYNC_STAGES-2:0], i_free};
      dn_sync_q   <= {dn_sync_q[SYNC_STAGES-2:0], i_driveNext};
      free_dly_q  <= free_sync_q[SYNC_STAGES-1];
      dn_dly_q    <= dn_sync_q[SYNC_STAGES-1];
    end
  end

  // Any change of a synchronised toggle level is one event; also derive tag FIFO status.
  always_comb begin
    free_ev_s    = free_sync_q[SYNC_STAGES-1] ^ free_dly_q;
    dn_ev_s      = dn_sync_q[SYNC_STAGES-1] ^ dn_dly_q;
    fifo_empty_s = (wr_ptr_q == rd_ptr_q);
    fifo_full_s  = ((wr_ptr_q ^ rd_ptr_q) == FULL_PAT);
    can_issue_s  = (inflight_q < DEPTH_C) && !fifo_full_s;
    pop_s        = dn_ev_s && !fifo_empty_s;
    head_tag_s   = tag_mem_q[rd_ptr_q[PW-1:0]];
  end

  // Pick the first active request at or after the priority pointer, wrapping at N.
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = '0;
    cand_s      = '0;
    for (int k = 0; k < N; k++) begin
      cand_s = {1'b0, ptr_q} + (IW + 1)'(k);
      if (cand_s >= N_C) begin
        cand_s = cand_s - N_C;
      end else begin
        cand_s = cand_s;
      end
      if (!sel_found_s && i_req[cand_s[IW-1:0]]) begin
        sel_found_s = 1'b1;
        sel_idx_s   = cand_s[IW-1:0];
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // Launch FSM: grant from IDLE, then hold off until the stage reports free.
  always_comb begin
    state_d = state_q;
    push_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel_found_s && can_issue_s) begin
          push_s  = 1'b1;
          state_d = ST_WAIT_FREE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_FREE: begin
        if (free_ev_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_FREE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Next values for grant/launch side, retire side and the in-flight counter.
  always_comb begin
    gnt_d      = '0;
    done_d     = '0;
    drive_d    = drive_q;
    fnext_d    = fnext_q;
    err_d      = err_q;
    ptr_d      = ptr_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    inflight_d = inflight_q;

    if (push_s) begin
      gnt_d[sel_idx_s] = 1'b1;
      drive_d          = ~drive_q;
      wr_ptr_d         = wr_ptr_q + PTR_ONE;
      if ({1'b0, sel_idx_s} == (N_C - N_ONE)) begin
        ptr_d = '0;
      end else begin
        ptr_d = sel_idx_s + IDX_ONE;
      end
    end else begin
      gnt_d = '0;
    end

    // freeNext is acknowledged even for an orphan event so the stage never stalls.
    if (dn_ev_s) begin
      fnext_d = ~fnext_q;
      if (fifo_empty_s) begin
        err_d = 1'b1;
      end else begin
        done_d[head_tag_s] = 1'b1;
        rd_ptr_d           = rd_ptr_q + PTR_ONE;
      end
    end else begin
      fnext_d = fnext_q;
    end

    case ({push_s, pop_s})
      2'b10:   inflight_d = inflight_q + CNT_ONE;
      2'b01:   inflight_d = inflight_q - CNT_ONE;
      default: inflight_d = inflight_q;
    endcase
  end

  // Register FSM state, pointers and every output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      drive_q    <= 1'b0;
      fnext_q    <= 1'b0;
      err_q      <= 1'b0;
      inflight_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      drive_q    <= drive_d;
      fnext_q    <= fnext_d;
      err_q      <= err_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Tag storage: the requester index of each launched token, in launch order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tag_mem_q[i] <= '0;
      end
    end else if (push_s) begin
      tag_mem_q[wr_ptr_q[PW-1:0]] <= sel_idx_s;
    end
  end

  assign o_gnt      = gnt_q;
  assign o_done     = done_q;
  assign o_drive    = drive_q;
  assign o_freeNext = fnext_q;
  assign o_inflight = inflight_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_cfifo_rr_scheduler.sv
// Self-checking bench for cfifo_rr_scheduler: scenario tasks plus randomized
// request masks, checked against a queue-based model of grants and retirement.

module tb_cfifo_rr_scheduler;

  localparam int N     = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [3:0] done;
  logic       drv;
  logic       free_l;
  logic       dn_l;
  logic       fn;
  logic [2:0] infl;
  logic       err;

  int checks = 0;
  int passes = 0;

  int   m_ptr;
  int   m_tags[$];
  logic m_drive;
  logic m_fn;

  cfifo_rr_scheduler #(.N(N), .DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .i_req(req), .o_gnt(gnt), .o_done(done),
    .o_drive(drv), .i_free(free_l), .i_driveNext(dn_l), .o_freeNext(fn),
    .o_inflight(infl), .o_err(err)
  );

  always #5 clk = ~clk;

  function automatic int rr_pick(logic [3:0] mask, int ptr);
    for (int k = 0; k < N; k++) begin
      int idx = (ptr + k) % N;
      if (mask[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [3:0] oh(int i);
    logic [3:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    req = '0; free_l = 1'b0; dn_l = 1'b0; rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    m_ptr = 0; m_tags.delete(); m_drive = 1'b0; m_fn = 1'b0;
  endtask

  task automatic model_grant(int idx);
    m_tags.push_back(idx);
    m_ptr   = (idx + 1) % N;
    m_drive = ~m_drive;
  endtask

  task automatic get_grant(output logic [3:0] g, output bit ok);
    ok = 1'b0; g = '0;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (gnt !== 4'b0) begin g = gnt; ok = 1'b1; break; end
    end
  endtask

  task automatic retire(output logic [3:0] d, output bit ok);
    dn_l = ~dn_l;
    ok = 1'b0; d = '0;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (done !== 4'b0) begin d = done; ok = 1'b1; break; end
    end
  endtask

  task automatic free_ret();
    repeat (3) tick();
    free_l = ~free_l;
  endtask

  task automatic test_reset();
    req = '0; free_l = 1'b0; dn_l = 1'b0; rst = 1'b1;
    #3;
    checks++; if (gnt !== 4'b0) $display("FAIL reset_gnt: got %b want 0000", gnt); else passes++;
    checks++; if (done !== 4'b0) $display("FAIL reset_done: got %b want 0000", done); else passes++;
    checks++; if (drv !== 1'b0) $display("FAIL reset_drive: got %b want 0", drv); else passes++;
    checks++; if (fn !== 1'b0) $display("FAIL reset_freenext: got %b want 0", fn); else passes++;
    checks++; if (infl !== 3'd0) $display("FAIL reset_inflight: got %0d want 0", infl); else passes++;
    checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else passes++;
    apply_reset();
  endtask

  task automatic test_single();
    logic [3:0] g, d, exp;
    bit ok;
    apply_reset();
    req = 4'b0001;
    exp = oh(rr_pick(req, m_ptr));
    get_grant(g, ok);
    checks++; if (!ok || g !== exp) $display("FAIL single_gnt: got %b want %b", g, exp); else passes++;
    model_grant(rr_pick(req, m_ptr));
    req = '0;
    checks++; if (drv !== m_drive) $display("FAIL single_drive: got %b want %b", drv, m_drive); else passes++;
    checks++; if (infl !== 3'(m_tags.size())) $display("FAIL single_inflight: got %0d want %0d", infl, m_tags.size()); else passes++;
    tick();
    checks++; if (gnt !== 4'b0) $display("FAIL single_gnt_width: got %b want 0000", gnt); else passes++;
    free_ret();
    repeat (5) tick();
    checks++; if (gnt !== 4'b0) $display("FAIL single_gnt_once: got %b want 0000", gnt); else passes++;
    exp = oh(m_tags.pop_front());
    m_fn = ~m_fn;
    retire(d, ok);
    checks++; if (!ok || d !== exp) $display("FAIL single_done: got %b want %b", d, exp); else passes++;
    checks++; if (fn !== m_fn) $display("FAIL single_freenext: got %b want %b", fn, m_fn); else passes++;
    checks++; if (infl !== 3'(m_tags.size())) $display("FAIL single_inflight_ret: got %0d want %0d", infl, m_tags.size()); else passes++;
  endtask

  task automatic test_rr_order();
    logic [3:0] g, d, exp, mask;
    bit ok;
    int idx;
    apply_reset();
    mask = 4'b1111;
    req  = mask;
    for (int i = 0; i < 4; i++) begin
      idx = rr_pick(mask, m_ptr);
      exp = oh(idx);
      get_grant(g, ok);
      checks++; if (!ok || g !== exp) $display("FAIL rr_gnt%0d: got %b want %b", i, g, exp); else passes++;
      model_grant(idx);
      mask[idx] = 1'b0;
      req = mask;
      free_ret();
    end
    repeat (5) tick();
    checks++; if (infl !== 3'(m_tags.size())) $display("FAIL rr_inflight: got %0d want %0d", infl, m_tags.size()); else passes++;
    for (int i = 0; i < 4; i++) begin
      exp = oh(m_tags.pop_front());
      m_fn = ~m_fn;
      retire(d, ok);
      checks++; if (!ok || d !== exp) $display("FAIL rr_done%0d: got %b want %b", i, d, exp); else passes++;
    end
    checks++; if (fn !== m_fn) $display("FAIL rr_freenext: got %b want %b", fn, m_fn); else passes++;
  endtask

  task automatic test_wrap();
    logic [3:0] g, d, exp, mask;
    bit ok;
    int idx;
    apply_reset();
    mask = 4'b1000;
    req  = mask;
    for (int i = 0; i < 3; i++) begin
      idx = rr_pick(mask, m_ptr);
      exp = oh(idx);
      get_grant(g, ok);
      checks++; if (!ok || g !== exp) $display("FAIL wrap_gnt%0d: got %b want %b", i, g, exp); else passes++;
      model_grant(idx);
      mask[idx] = 1'b0;
      if (i == 0) mask = 4'b1001;
      req = mask;
      free_ret();
    end
    repeat (5) tick();
    while (m_tags.size() > 0) begin
      exp = oh(m_tags.pop_front());
      retire(d, ok);
      checks++; if (!ok || d !== exp) $display("FAIL wrap_done: got %b want %b", d, exp); else passes++;
    end
  endtask

  task automatic test_full();
    logic [3:0] g, d, exp, mask;
    int cnt[4];
    bit ok;
    int idx, ngr;
    apply_reset();
    cnt = '{2, 2, 1, 1};
    for (int i = 0; i < 4; i++) mask[i] = (cnt[i] > 0);
    req = mask;
    for (int i = 0; i < 4; i++) begin
      idx = rr_pick(mask, m_ptr);
      exp = oh(idx);
      get_grant(g, ok);
      checks++; if (!ok || g !== exp) $display("FAIL full_gnt%0d: got %b want %b", i, g, exp); else passes++;
      model_grant(idx);
      cnt[idx]--;
      for (int j = 0; j < 4; j++) mask[j] = (cnt[j] > 0);
      req = mask;
      free_ret();
    end
    ngr = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (gnt !== 4'b0) ngr++;
    end
    checks++; if (ngr !== 0) $display("FAIL full_no_grant: got %0d grants want 0", ngr); else passes++;
    checks++; if (infl !== 3'(m_tags.size())) $display("FAIL full_inflight4: got %0d want %0d", infl, m_tags.size()); else passes++;
    exp = oh(m_tags.pop_front());
    retire(d, ok);
    checks++; if (!ok || d !== exp) $display("FAIL full_done: got %b want %b", d, exp); else passes++;
    checks++; if (infl !== 3'(m_tags.size())) $display("FAIL full_inflight3: got %0d want %0d", infl, m_tags.size()); else passes++;
    idx = rr_pick(mask, m_ptr);
    exp = oh(idx);
    get_grant(g, ok);
    checks++; if (!ok || g !== exp) $display("FAIL full_gnt5: got %b want %b", g, exp); else passes++;
    model_grant(idx);
    checks++; if (infl !== 3'(m_tags.size())) $display("FAIL full_inflight_refill: got %0d want %0d", infl, m_tags.size()); else passes++;
    req = '0;
  endtask

  task automatic test_simultaneous();
    logic [3:0] g, exp_g, exp_d, mask;
    bit ok;
    int idx;
    apply_reset();
    mask = 4'b0011;
    req  = mask;
    for (int i = 0; i < 2; i++) begin
      idx = rr_pick(mask, m_ptr);
      get_grant(g, ok);
      model_grant(idx);
      mask[idx] = 1'b0;
      req = mask;
      free_ret();
    end
    repeat (5) tick();
    dn_l = ~dn_l;
    tick();
    tick();
    req   = 4'b0100;
    exp_g = oh(rr_pick(req, m_ptr));
    exp_d = oh(m_tags.pop_front());
    model_grant(rr_pick(req, m_ptr));
    tick();
    req = '0;
    checks++; if (gnt !== exp_g) $display("FAIL simul_gnt: got %b want %b", gnt, exp_g); else passes++;
    checks++; if (done !== exp_d) $display("FAIL simul_done: got %b want %b", done, exp_d); else passes++;
    checks++; if (infl !== 3'(m_tags.size())) $display("FAIL simul_inflight: got %0d want %0d", infl, m_tags.size()); else passes++;
  endtask

  task automatic test_error();
    int nd;
    apply_reset();
    free_l = ~free_l;
    nd = 0;
    for (int t = 0; t < 6; t++) begin
      tick();
      if (gnt !== 4'b0) nd++;
    end
    checks++; if (err !== 1'b0) $display("FAIL err_free_idle: got %b want 0", err); else passes++;
    checks++; if (nd !== 0) $display("FAIL err_free_idle_gnt: got %0d grants want 0", nd); else passes++;
    dn_l = ~dn_l;
    m_fn = ~m_fn;
    nd = 0;
    for (int t = 0; t < 6; t++) begin
      tick();
      if (done !== 4'b0) nd++;
    end
    checks++; if (err !== 1'b1) $display("FAIL err_set: got %b want 1", err); else passes++;
    checks++; if (fn !== m_fn) $display("FAIL err_freenext: got %b want %b", fn, m_fn); else passes++;
    checks++; if (nd !== 0) $display("FAIL err_no_done: got %0d pulses want 0", nd); else passes++;
    checks++; if (infl !== 3'd0) $display("FAIL err_inflight: got %0d want 0", infl); else passes++;
    apply_reset();
    checks++; if (err !== 1'b0) $display("FAIL err_cleared: got %b want 0", err); else passes++;
  endtask

  task automatic test_reset_midflight();
    logic [3:0] g, mask;
    bit ok;
    int idx, nd;
    apply_reset();
    mask = 4'b0111;
    req  = mask;
    for (int i = 0; i < 3; i++) begin
      idx = rr_pick(mask, m_ptr);
      get_grant(g, ok);
      model_grant(idx);
      mask[idx] = 1'b0;
      req = mask;
      free_ret();
    end
    repeat (5) tick();
    checks++; if (infl !== 3'(m_tags.size())) $display("FAIL mid_inflight3: got %0d want %0d", infl, m_tags.size()); else passes++;
    dn_l = ~dn_l;
    tick();
    #3;
    rst = 1'b1;
    #1;
    checks++; if ({gnt, done, drv, fn, err} !== 11'b0) $display("FAIL mid_async_clear: got %b want 0", {gnt, done, drv, fn, err}); else passes++;
    checks++; if (infl !== 3'd0) $display("FAIL mid_inflight_clear: got %0d want 0", infl); else passes++;
    dn_l = 1'b0; free_l = 1'b0; req = '0;
    tick();
    tick();
    rst = 1'b0;
    m_ptr = 0; m_tags.delete(); m_drive = 1'b0; m_fn = 1'b0;
    nd = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (done !== 4'b0) nd++;
    end
    checks++; if (nd !== 0) $display("FAIL mid_no_done: got %0d pulses want 0", nd); else passes++;
  endtask

  task automatic test_random();
    logic [3:0] g, d, exp, mask;
    bit ok;
    int idx;
    apply_reset();
    for (int r = 0; r < 5; r++) begin
      mask = 4'($urandom_range(1, 15));
      req  = mask;
      while (mask != 4'b0) begin
        idx = rr_pick(mask, m_ptr);
        exp = oh(idx);
        get_grant(g, ok);
        checks++; if (!ok || g !== exp) $display("FAIL rand_gnt: got %b want %b", g, exp); else passes++;
        model_grant(idx);
        mask[idx] = 1'b0;
        req = mask;
        checks++; if (infl !== 3'(m_tags.size())) $display("FAIL rand_inflight: got %0d want %0d", infl, m_tags.size()); else passes++;
        if (m_tags.size() == DEPTH || $urandom_range(0, 1) == 1) begin
          exp = oh(m_tags.pop_front());
          m_fn = ~m_fn;
          retire(d, ok);
          checks++; if (!ok || d !== exp) $display("FAIL rand_done: got %b want %b", d, exp); else passes++;
        end
        free_ret();
      end
      repeat (5) tick();
      checks++; if (drv !== m_drive) $display("FAIL rand_drive: got %b want %b", drv, m_drive); else passes++;
    end
    while (m_tags.size() > 0) begin
      exp = oh(m_tags.pop_front());
      m_fn = ~m_fn;
      retire(d, ok);
      checks++; if (!ok || d !== exp) $display("FAIL rand_drain: got %b want %b", d, exp); else passes++;
    end
    checks++; if (fn !== m_fn) $display("FAIL rand_freenext: got %b want %b", fn, m_fn); else passes++;
    checks++; if (infl !== 3'd0) $display("FAIL rand_inflight_end: got %0d want 0", infl); else passes++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_order();
    test_wrap();
    test_full();
    test_simultaneous();
    test_error();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cfifo_rr_scheduler.md
Name: cfifo_rr_scheduler

Overview:
- Clocked round-robin scheduler that shares one click-based single-stage micropipeline FIFO among N synchronous requesters.
- Issues 2-phase drive transitions into the stage and waits for the stage's free transition before issuing the next token.
- Tags every in-flight token with its requester index, so the exit event from the stage is returned to the correct requester as a done pulse.
- Sits between the clocked control domain and the asynchronous pipeline; it also returns the downstream free acknowledge to the stage.

Parameters:
- N, 4, number of requesters (2..16).
- DEPTH, 4, maximum tokens in flight; also the depth of the tag FIFO (power of 2).
- SYNC_STAGES, 2, flip-flop synchroniser depth for the asynchronous inputs (>=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- i_req  in  N  level request per requester; held high until that requester's o_gnt bit pulses.
- o_gnt  out  N  one-hot, 1-cycle pulse: request accepted, token launched.
- o_done  out  N  one-hot, 1-cycle pulse: that requester's token left the stage.
- o_drive  out  1  2-phase toggle to the stage drive input.
- i_free  in  1  2-phase toggle from the stage free output; asynchronous, synchronised internally.
- i_driveNext  in  1  2-phase toggle from the stage driveNext output; asynchronous, synchronised internally.
- o_freeNext  out  1  2-phase toggle to the stage freeNext input (downstream acknowledge).
- o_inflight  out  clog2(DEPTH+1)  number of tokens launched but not yet retired.
- o_err  out  1  sticky flag: driveNext event seen while the tag FIFO is empty.

Behaviour:
- Reset (async assert, sync release): all outputs are 0, FSM is in IDLE, priority pointer is 0, tag FIFO is empty, and synchroniser and edge-history flops are 0.
  - The stage shares the same rst, so toggle levels restart from 0 on both sides.
- Event detection: after SYNC_STAGES flops, an event is a synchronised value differing from its 1-cycle-delayed copy. Each input edge yields exactly one 1-cycle event.
- Input FSM:
  - IDLE: if any i_req bit is high and o_inflight < DEPTH, select the first set bit at or after the priority pointer, wrapping from N-1 to 0. On the next edge:
    - pulse o_gnt[sel];
    - toggle o_drive;
    - push sel into the tag FIFO;
    - set priority pointer = (sel+1) mod N;
    - go to WAIT_FREE.
  - If o_inflight == DEPTH, stay in IDLE and issue no grant.
  - WAIT_FREE: no grants are issued. On a free event, go to IDLE; a new grant can then fire on the following edge.
  - Minimum grant spacing is therefore 2 cycles plus the free round-trip.
  - A free event while in IDLE is ignored and does not set o_err.
- Output path, runs concurrently with the input FSM. On a driveNext event with the tag FIFO non-empty, on the next edge:
  - pop the tag;
  - pulse o_done[tag];
  - toggle o_freeNext.
- driveNext event with an empty tag FIFO: set o_err; no pop, no o_done, and o_freeNext is still toggled so the stage is not deadlocked.
- o_inflight:
  - +1 on push, -1 on pop, unchanged when push and pop occur in the same cycle.
  - Never exceeds DEPTH; never underflows.
- Tag FIFO:
  - read and write pointers have an extra wrap bit;
  - full when the pointers differ only in the MSB;
  - wrap-around is transparent;
  - ordering is strictly FIFO, because the stage preserves order.
- Requester dropping i_req before its grant: the request is simply not selected; there is no partial state.
- Reset mid-operation: in-flight tags are discarded, no o_done pulses are emitted, and o_err is cleared.

Test Plan:
- N=4, i_req=4'b0001 held until grant, stage model with free returning 3 cycles after drive:
  - o_gnt=0001 pulses once;
  - o_drive goes 0->1;
  - o_inflight=1;
  - driveNext toggled gives o_done=0001, o_freeNext 0->1, o_inflight=0.
- i_req=4'b1111 held continuously, each requester dropping its bit after grant:
  - grant order is 0001, 0010, 0100, 1000;
  - o_done pulses in the same order.
- Pointer wrap: after granting index 3, i_req=4'b1001 grants 0001 first, then 1000.
- Full: stage never toggles driveNext, 6 requests issued:
  - exactly 4 grants; o_inflight=4;
  - no 5th grant until one driveNext event, after which o_inflight goes 3 and then 4.
- Simultaneous events: a grant push and a driveNext pop in the same cycle leave o_inflight unchanged at 2, and o_done carries the oldest tag.
- Error and reset:
  - a driveNext toggle with an empty FIFO gives o_err=1 and an o_freeNext toggle;
  - asserting rst mid-flight with o_inflight=3 clears all outputs to 0 asynchronously, with no o_done afterwards.
